// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - shared payload type and stage-count helper
package pipelined_addsub_pkg;

    localparam int MAX_W = 64;

    // Fields are sized for the widest legal operand; bits above WIDTH stay zero and are trimmed.
    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             carry;
        logic             ovf;
        logic [MAX_W-1:0] sum;
        logic [MAX_W-1:0] rem_a;
        logic [MAX_W-1:0] rem_b;
    } stage_t;

    function automatic int calc_stages(input int width, input int bps);
        return (width + bps - 1) / bps;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_addsub_stage.sv
// rtl/pipelined_addsub_stage.sv - ripple chunk adder used by each pipeline stage
module addsub_stage #(
    parameter int N = 2
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    output logic [N-1:0] s_o,
    output logic         co_o
);

    logic [N:0] carry;

    assign carry[0] = ci_i;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a_i  (a_i[i]),
            .b_i  (b_i[i]),
            .ci_i (carry[i]),
            .s_o  (s_o[i]),
            .co_o (carry[i+1])
        );
    end

    assign co_o = carry[N];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - carry-pipelined adder/subtractor with valid/ready handshake
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, BITS_PER_STAGE);

    logic   advance;
    stage_t entry;
    stage_t stage_d [STAGES];
    stage_t stage_q [STAGES];
    stage_t last_q;
    logic   unused_last;

    assign advance  = en && (!out_valid || out_ready);
    assign in_ready = advance;

    // Subtraction becomes a + ~b + !cin, so the first carry-in is cin ^ sub.
    always_comb begin
        entry       = '0;
        entry.valid = in_valid && in_ready;
        entry.sub   = sub;
        entry.carry = cin ^ sub;
        entry.rem_a = MAX_W'(a);
        entry.rem_b = MAX_W'(b);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * BITS_PER_STAGE;
        localparam int HI   = (((k + 1) * BITS_PER_STAGE < WIDTH) ? (k + 1) * BITS_PER_STAGE : WIDTH) - 1;
        localparam int N    = HI - LO + 1;
        localparam logic [MAX_W-1:0] DONE_MASK = {MAX_W{1'b1}} >> (MAX_W - 1 - HI);

        stage_t       prev;
        stage_t       d;
        logic [N-1:0] b_eff;
        logic [N-1:0] s_chunk;
        logic         co;

        if (k == 0) begin : g_first
            assign prev = entry;
        end else begin : g_next
            assign prev = stage_q[k-1];
        end

        assign b_eff = prev.rem_b[HI:LO] ^ {N{prev.sub}};

        addsub_stage #(.N(N)) u_chunk (
            .a_i  (prev.rem_a[HI:LO]),
            .b_i  (b_eff),
            .ci_i (prev.carry),
            .s_o  (s_chunk),
            .co_o (co)
        );

        // Resolved operand bits are dropped so only the still-needed upper bits keep flops.
        always_comb begin
            d             = prev;
            d.carry       = co;
            d.sum[HI:LO]  = s_chunk;
            d.rem_a       = prev.rem_a & ~DONE_MASK;
            d.rem_b       = prev.rem_b & ~DONE_MASK;
            d.ovf         = (k == STAGES - 1) && (prev.rem_a[HI] == b_eff[N-1])
                            && (s_chunk[N-1] != prev.rem_a[HI]);
        end

        assign stage_d[k] = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
        end
    end

    assign last_q      = stage_q[STAGES-1];
    assign out_valid   = last_q.valid;
    assign s           = last_q.sum[WIDTH-1:0];
    assign c           = last_q.carry;
    assign ovf         = last_q.ovf;
    assign unused_last = ^{last_q.sub, last_q.sum, last_q.rem_a, last_q.rem_b};

endmodule
